// File: rtl/ivl_uvm_ovl_window_seq.sv
// ivl_uvm_ovl_window_seq
//
// Stimulus sequencer for an ovl_window checker. Each accepted request plays out one
// bus write transaction: a write pulse (start_event), the bus grant (test_expr) held
// across a programmable window, then a write-ack pulse (end_event). A single-cycle
// grant drop can be injected inside the window, and the sequencer reports whether the
// downstream checker is expected to fire.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   start        in   transaction request, sampled only when idle
//   win_len      in   number of window cycles between the start and end pulses
//   drop_en      in   enable grant-drop injection
//   drop_at      in   0-based window cycle in which the grant drops
//   start_event  out  write pulse, to checker start_event
//   test_expr    out  bus grant, to checker test_expr
//   end_event    out  write-ack pulse, to checker end_event
//   busy         out  high from the start pulse through the gap cycle
//   done         out  one-cycle completion pulse in the gap cycle
//   expect_fire  out  valid with done; 1 when a drop was injected inside the window
//   txn_count    out  completed-transaction counter, wraps

module ivl_uvm_ovl_window_seq #(
   parameter int unsigned WIN_W = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   input  logic             drop_en,
   input  logic [WIN_W-1:0] drop_at,
   output logic             start_event,
   output logic             test_expr,
   output logic             end_event,
   output logic             busy,
   output logic             done,
   output logic             expect_fire,
   output logic [CNT_W-1:0] txn_count
);

   typedef enum logic [2:0] {StIdle, StStart, StWindow, StEnd, StGap} state_e;

   state_e           state_q, state_d;
   logic [WIN_W-1:0] cnt_q, cnt_d;
   logic [WIN_W-1:0] len_q, len_d;
   logic [WIN_W-1:0] at_q, at_d;
   logic             den_q, den_d;
   logic             flag_q, flag_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             drop_hit;

   logic start_event_q, test_expr_q, end_event_q, busy_q, done_q, expect_fire_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      at_d     = at_q;
      den_d    = den_q;
      flag_d   = flag_q;
      count_d  = count_q;
      drop_hit = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StStart;
               len_d   = win_len;
               den_d   = drop_en;
               at_d    = drop_at;
               cnt_d   = '0;
               flag_d  = 1'b0;
            end
         end
         StStart:  state_d = (len_q != '0) ? StWindow : StEnd;
         StWindow: begin
            // len_q is non-zero here, so len_q - 1 cannot underflow
            if (cnt_q == len_q - WIN_W'(1)) begin
               state_d = StEnd;
            end else begin
               cnt_d = cnt_q + WIN_W'(1);
            end
         end
         StEnd:    state_d = StGap;
         StGap:    state_d = StIdle;
         default:  state_d = StIdle;
      endcase

      // Outputs are registered from next-state values, so the drop is decided for the
      // cycle being entered. cnt_d < len_d always holds in the window, which makes an
      // out-of-range drop_at naturally inert.
      drop_hit = (state_d == StWindow) && den_d && (cnt_d == at_d);
      if (drop_hit) begin
         flag_d = 1'b1;
      end
      if (state_d == StGap) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         len_q         <= '0;
         at_q          <= '0;
         den_q         <= 1'b0;
         flag_q        <= 1'b0;
         count_q       <= '0;
         start_event_q <= 1'b0;
         test_expr_q   <= 1'b0;
         end_event_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         expect_fire_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         len_q         <= len_d;
         at_q          <= at_d;
         den_q         <= den_d;
         flag_q        <= flag_d;
         count_q       <= count_d;
         start_event_q <= (state_d == StStart);
         test_expr_q   <= (state_d == StStart) || (state_d == StEnd) ||
                          ((state_d == StWindow) && !drop_hit);
         end_event_q   <= (state_d == StEnd);
         busy_q        <= (state_d != StIdle);
         done_q        <= (state_d == StGap);
         expect_fire_q <= (state_d == StGap) && flag_d;
      end
   end

   assign start_event = start_event_q;
   assign test_expr   = test_expr_q;
   assign end_event   = end_event_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign expect_fire = expect_fire_q;
   assign txn_count   = count_q;

endmodule

// File: tb/tb_ivl_uvm_ovl_window_seq.sv
// Testbench for ivl_uvm_ovl_window_seq: table of directed transactions whose cycle-by-
// cycle waveforms are derived from the timing rules, plus hand-written reset, held-start
// and reset-mid-window sequences.

module tb_ivl_uvm_ovl_window_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  win_len = '0;
   logic        drop_en = 1'b0;
   logic [7:0]  drop_at = '0;
   logic        start_event, test_expr, end_event, busy, done, expect_fire;
   logic [15:0] txn_count;

   int passed = 0;
   int total  = 0;
   int exp_count = 0;

   ivl_uvm_ovl_window_seq #(.WIN_W(8), .CNT_W(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .win_len     (win_len),
      .drop_en     (drop_en),
      .drop_at     (drop_at),
      .start_event (start_event),
      .test_expr   (test_expr),
      .end_event   (end_event),
      .busy        (busy),
      .done        (done),
      .expect_fire (expect_fire),
      .txn_count   (txn_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      int   len;
      logic en;
      int   at;
      logic fire;   // hand-determined: drop lands inside the window
      logic poke;   // fire a second start and scramble fields while busy
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [5:0] outs();
      return {start_event, test_expr, end_event, busy, done, expect_fire};
   endfunction

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy === 1'b1 && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (n >= 300) chk({name, " idle timeout"}, 32'd1, 32'd0);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic [5:0] exp;
      logic se, te, ee, bs, dn, ef;
      logic open, fired;
      @(negedge clock);
      win_len = 8'(v.len);
      drop_en = v.en;
      drop_at = 8'(v.at);
      start   = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      open  = 1'b0;
      fired = 1'b0;
      for (int k = 1; k <= v.len + 4; k++) begin
         @(negedge clock);
         se = (k == 1);
         ee = (k == v.len + 2);
         dn = (k == v.len + 3);
         bs = (k >= 1) && (k <= v.len + 3);
         te = (k <= v.len + 2) && !(v.en && v.at < v.len && k == v.at + 2);
         ef = dn && v.fire;
         exp = {se, te, ee, bs, dn, ef};
         chk($sformatf("vec%0d cyc%0d outs", idx, k), 32'(outs()), 32'(exp));
         // Minimal ovl_window model: grant must hold strictly between start and end
         if (open && !end_event && !test_expr) fired = 1'b1;
         if (start_event) open = 1'b1;
         if (end_event) open = 1'b0;
         if (dn) begin
            exp_count++;
            chk($sformatf("vec%0d txn_count", idx), 32'(txn_count), 32'(exp_count));
         end
         if (v.poke && k == 3) begin
            start = 1'b1; win_len = 8'd9; drop_en = 1'b1; drop_at = 8'd0;
         end
         if (v.poke && k == 4) start = 1'b0;
      end
      chk($sformatf("vec%0d checker fired", idx), 32'(fired), 32'(v.fire));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{len: 5, en: 1'b0, at: 0, fire: 1'b0, poke: 1'b1};
      vecs[1] = '{len: 5, en: 1'b1, at: 2, fire: 1'b1, poke: 1'b0};
      vecs[2] = '{len: 0, en: 1'b0, at: 0, fire: 1'b0, poke: 1'b0};
      vecs[3] = '{len: 5, en: 1'b1, at: 5, fire: 1'b0, poke: 1'b0};
      vecs[4] = '{len: 3, en: 1'b1, at: 0, fire: 1'b1, poke: 1'b0};
      vecs[5] = '{len: 0, en: 1'b1, at: 0, fire: 1'b0, poke: 1'b0};
      vecs[6] = '{len: 1, en: 1'b1, at: 0, fire: 1'b1, poke: 1'b0};

      // Reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk($sformatf("reset outs %0d", i), 32'(outs()), 32'd0);
      end
      chk("reset txn_count", 32'(txn_count), 32'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("post-reset outs", 32'(outs()), 32'd0);
      chk("post-reset txn_count", 32'(txn_count), 32'd0);

      foreach (vecs[i]) begin
         run_vec(i, vecs[i]);
         wait_idle($sformatf("vec%0d", i));
      end

      // Held start, win_len=1: accepts at edge N and N+5
      @(negedge clock);
      win_len = 8'd1; drop_en = 1'b0; drop_at = 8'd0; start = 1'b1;
      @(posedge clock);
      #1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         chk($sformatf("held cyc%0d start_event", k), 32'(start_event),
             32'((k == 1) || (k == 6)));
         if (k == 6) start = 1'b0;
      end
      wait_idle("held");
      exp_count += 2;
      chk("held txn_count", 32'(txn_count), 32'(exp_count));

      // Reset during window cycle 3 of win_len=8
      @(negedge clock);
      win_len = 8'd8; drop_en = 1'b0; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      for (int k = 1; k <= 5; k++) @(negedge clock);
      chk("mid-window test_expr before reset", 32'(test_expr), 32'd1);
      reset = 1'b1;
      #1;
      chk("async reset outs", 32'(outs()), 32'd0);
      chk("async reset txn_count", 32'(txn_count), 32'd0);
      exp_count = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (k == 1) reset = 1'b0;
         if (k >= 1) chk($sformatf("no done after reset %0d", k), 32'(done), 32'd0);
      end
      vecs[0] = '{len: 2, en: 1'b0, at: 0, fire: 1'b0, poke: 1'b0};
      run_vec(7, vecs[0]);
      wait_idle("after reset");
      chk("final txn_count", 32'(txn_count), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
